game_ctrl: RTL and testbench

Match controller for the pong core. It consumes the ball block's `out_left`/`out_right` edge events and drives its `ball_reset`, `speed` and `entropy` inputs, closing the loop between scoring and serving. It keeps both scores, times the serve pause, ramps ball speed during a rally, and declares the winner. It runs on the same ~2 kHz game clock as the ball.

---
 rtl/game_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Pong match controller: scoring, serve pause, speed ramp and winner.
// Ports: clk/reset, start, out_left/out_right in; ball_reset, speed, entropy, scores, game_over, winner out.
module game_ctrl #(
  parameter int unsigned SERVE_DELAY = 2000,
  parameter int unsigned RAMP_PERIOD = 4000,
  parameter int unsigned SPEED_INIT  = 4,
  parameter int unsigned SPEED_MAX   = 15,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       out_left,
  input  logic       out_right,
  output logic       ball_reset,
  output logic [3:0] speed,
  output logic [4:0] entropy,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner
);

  localparam logic [15:0] SRV_LOAD  = 16'(SERVE_DELAY - 1);
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_PERIOD - 1);
  localparam logic [3:0]  SPD_INIT  = 4'(SPEED_INIT);
  localparam logic [3:0]  SPD_MAX   = 4'(SPEED_MAX);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] srv_cnt_q, srv_cnt_d;
  logic [15:0] ramp_q, ramp_d;
  logic        ball_reset_q, ball_reset_d;
  logic [3:0]  speed_q, speed_d;
  logic [3:0]  score_l_q, score_l_d;
  logic [3:0]  score_r_q, score_r_d;
  logic        game_over_q, game_over_d;
  logic        winner_q, winner_d;
  logic [3:0]  pt_new;

  // out_left has priority: it scores for the right player
  assign pt_new = out_left ? score_r_q + 4'd1 : score_l_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    srv_cnt_d    = srv_cnt_q;
    ramp_d       = ramp_q;
    ball_reset_d = ball_reset_q;
    speed_d      = speed_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    // x^16+x^14+x^13+x^11+1, right-shifting form
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
              lfsr_q[15:1]};

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d      = S_SERVE;
          score_l_d    = '0;
          score_r_d    = '0;
          game_over_d  = 1'b0;
          srv_cnt_d    = SRV_LOAD;
          ball_reset_d = 1'b1;
          speed_d      = SPD_INIT;
        end
      end
      S_SERVE: begin
        if (srv_cnt_q == '0) begin
          state_d      = S_PLAY;
          ball_reset_d = 1'b0;
          ramp_d       = '0;
        end else begin
          srv_cnt_d = srv_cnt_q - 16'd1;
        end
      end
      S_PLAY: begin
        if (ramp_q == RAMP_LAST) begin
          ramp_d = '0;
          if (speed_q < SPD_MAX) speed_d = speed_q + 4'd1;
        end else begin
          ramp_d = ramp_q + 16'd1;
        end
        if (out_left || out_right) begin
          if (out_left) score_r_d = pt_new;
          else          score_l_d = pt_new;
          ball_reset_d = 1'b1;
          if (pt_new == WIN) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            winner_d    = out_left;
            speed_d     = '0;
          end else begin
            state_d   = S_SERVE;
            srv_cnt_d = SRV_LOAD;
            speed_d   = SPD_INIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 16'hACE1;
      srv_cnt_q    <= '0;
      ramp_q       <= '0;
      ball_reset_q <= 1'b1;
      speed_q      <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      srv_cnt_q    <= srv_cnt_d;
      ramp_q       <= ramp_d;
      ball_reset_q <= ball_reset_d;
      speed_q      <= speed_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign ball_reset = ball_reset_q;
  assign speed      = speed_q;
  assign entropy    = lfsr_q[4:0];
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: timeline model checked every cycle plus directed literals.
module tb_game_ctrl;

  localparam int SD = 4;
  localparam int RP = 8;
  localparam int SI = 4;
  localparam int SM = 6;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       out_left = 1'b0;
  logic       out_right = 1'b0;
  logic       ball_reset;
  logic [3:0] speed;
  logic [4:0] entropy;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  game_ctrl #(
    .SERVE_DELAY(SD),
    .RAMP_PERIOD(RP),
    .SPEED_INIT(SI),
    .SPEED_MAX(SM),
    .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .out_left(out_left),
    .out_right(out_right),
    .ball_reset(ball_reset),
    .speed(speed),
    .entropy(entropy),
    .score_l(score_l),
    .score_r(score_r),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a match is a timeline. play_start is the edge at which the
  // serve pause ends; speed follows from elapsed play time.
  int          t = 0;
  int          m_mode = 0;  // 0 idle, 1 match, 2 over
  int          m_sl = 0;
  int          m_sr = 0;
  int          m_win = 0;
  int          play_start = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk or posedge reset) begin
    int fb;
    if (reset) begin
      m_mode = 0;
      m_sl = 0;
      m_sr = 0;
      m_win = 0;
      m_lfsr = 16'hACE1;
    end else begin
      t++;
      fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | 16'(fb << 15);
      if (m_mode != 1 && start) begin
        m_mode = 1;
        m_sl = 0;
        m_sr = 0;
        play_start = t + SD;
      end else if (m_mode == 1 && t > play_start
                   && (out_left || out_right)) begin
        if (out_left) m_sr++;
        else          m_sl++;
        if (m_sr == WS || m_sl == WS) begin
          m_mode = 2;
          m_win = out_left ? 1 : 0;
        end else begin
          play_start = t + SD;
        end
      end
    end
  end

  always @(posedge clk) begin
    int e_br, e_spd;
    #1;
    if (m_mode == 1 && t >= play_start) begin
      e_br = 0;
      e_spd = SI + (t - play_start) / RP;
      if (e_spd > SM) e_spd = SM;
    end else begin
      e_br = 1;
      e_spd = (m_mode == 1) ? SI : 0;
    end
    chk("m_ball_reset", 16'(ball_reset), 16'(e_br));
    chk("m_speed", 16'(speed), 16'(e_spd));
    chk("m_entropy", 16'(entropy), 16'(m_lfsr[4:0]));
    chk("m_score_l", 16'(score_l), 16'(m_sl));
    chk("m_score_r", 16'(score_r), 16'(m_sr));
    chk("m_game_over", 16'(game_over), 16'(m_mode == 2));
    chk("m_winner", 16'(winner), 16'(m_win));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk("rst_br", 16'(ball_reset), 16'd1);
    chk("rst_speed", 16'(speed), 16'd0);
    chk("rst_scores", 16'({score_l, score_r}), 16'd0);
    chk("rst_over", 16'(game_over), 16'd0);
    chk("rst_entropy", 16'(entropy), 16'd1);
    reset = 1'b0;
    cyc(1);
    chk("entropy_step", 16'(entropy), 16'd16);

    // serve timing
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("serve_speed", 16'(speed), 16'd4);
    chk("serve_br0", 16'(ball_reset), 16'd1);
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      chk("serve_br", 16'(ball_reset), 16'd1);
    end
    cyc(1);
    chk("play_br", 16'(ball_reset), 16'd0);

    // start ignored in PLAY; speed ramp and saturation
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(6);
    chk("ramp_e7", 16'(speed), 16'd4);
    cyc(1);
    chk("ramp_e8", 16'(speed), 16'd5);
    cyc(8);
    chk("ramp_e16", 16'(speed), 16'd6);
    cyc(24);
    chk("ramp_sat", 16'(speed), 16'd6);

    // held out_left scores once
    out_left = 1'b1;
    cyc(1);
    chk("pt_score_r", 16'(score_r), 16'd1);
    chk("pt_br", 16'(ball_reset), 16'd1);
    chk("pt_speed", 16'(speed), 16'd4);
    cyc(2);
    out_left = 1'b0;
    chk("held_once", 16'(score_r), 16'd1);
    cyc(2);
    chk("reserve_br", 16'(ball_reset), 16'd0);

    // both high: left edge wins
    out_left = 1'b1;
    out_right = 1'b1;
    cyc(1);
    out_left = 1'b0;
    out_right = 1'b0;
    chk("both_r", 16'(score_r), 16'd2);
    chk("both_l", 16'(score_l), 16'd0);
    cyc(4);
    out_left = 1'b1;
    cyc(1);
    out_left = 1'b0;
    chk("over_flag", 16'(game_over), 16'd1);
    chk("over_winner", 16'(winner), 16'd1);
    chk("over_speed", 16'(speed), 16'd0);
    out_right = 1'b1;
    cyc(3);
    out_right = 1'b0;
    chk("over_held", 16'({score_l, score_r}), 16'h0003);

    // restart from OVER, then a left point, then reset mid-serve
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart_sc", 16'({score_l, score_r}), 16'd0);
    chk("restart_go", 16'(game_over), 16'd0);
    chk("restart_br", 16'(ball_reset), 16'd1);
    cyc(4);
    out_right = 1'b1;
    cyc(1);
    out_right = 1'b0;
    chk("left_pt", 16'(score_l), 16'd1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_br", 16'(ball_reset), 16'd1);
    chk("mid_rst_spd", 16'(speed), 16'd0);
    chk("mid_rst_sc", 16'({score_l, score_r}), 16'd0);
    reset = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rs_serve_br", 16'(ball_reset), 16'd1);
      cyc(1);
    end
    chk("rs_play_br", 16'(ball_reset), 16'd0);

    // left player wins
    for (int k = 0; k < 3; k++) begin
      out_right = 1'b1;
      cyc(1);
      out_right = 1'b0;
      if (k < 2) cyc(4);
    end
    chk("lwin_over", 16'(game_over), 16'd1);
    chk("lwin_winner", 16'(winner), 16'd0);
    chk("lwin_score", 16'(score_l), 16'd3);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
